// File: rtl/led_pattern_if.sv
// ============================================================================
// Module      : led_pattern_if
// Description : Control/status bundle between the switch decode and the LED
//               pattern engine.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface led_pattern_if #(
    parameter int N_LEDS = 4,
    parameter int N_CH   = 3,
    parameter int N_REF  = 4
);
    localparam int REF_W = (N_REF > 1) ? $clog2(N_REF) : 1;

    logic                     i_enable;
    logic [REF_W-1:0]         i_ref_sel;
    logic                     i_dir;
    logic [1:0]               i_mode;
    logic [N_CH-1:0]          i_color;
    logic [N_LEDS-1:0]        o_led;
    logic [N_LEDS*N_CH-1:0]   o_led_ch;
    logic                     o_tick;

    modport master (
        output i_enable, i_ref_sel, i_dir, i_mode, i_color,
        input  o_led, o_led_ch, o_tick
    );

    modport slave (
        input  i_enable, i_ref_sel, i_dir, i_mode, i_color,
        output o_led, o_led_ch, o_tick
    );
endinterface

`default_nettype wire

// File: rtl/led_pattern_engine.sv
// ============================================================================
// Module      : led_pattern_engine
// Description : N-LED shift / flash / ping-pong / hold pattern generator with
//               run-time selectable step rate and colour-channel fan-out.
//               Optional macro LED_PING_PONG_EN enables the ping-pong mode.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module led_pattern_engine #(
    parameter int N_LEDS     = 4,
    parameter int N_CH       = 3,
    parameter int N_REF      = 4,
    parameter int BASE_LIMIT = 4
) (
    input  wire logic  clock,
    input  wire logic  i_ck_reset,
    led_pattern_if.slave bus
);
    localparam int REF_W = (N_REF > 1) ? $clog2(N_REF) : 1;
    localparam int CNT_W = $clog2(BASE_LIMIT << (N_REF - 1));
    localparam logic [N_LEDS-1:0] c_pat_one = N_LEDS'(1);

`ifdef LED_PING_PONG_EN
    typedef enum logic [1:0] {
        S_SHIFT = 2'd0,
        S_FLASH = 2'd1,
        S_PING  = 2'd2,
        S_HOLD  = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        S_SHIFT = 2'd0,
        S_FLASH = 2'd1,
        S_HOLD  = 2'd3
    } state_t;
`endif

    state_t              state_q, state_d, w_target;
    logic [1:0]          mode_q;
    logic [REF_W-1:0]    ref_q, ref_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [N_LEDS-1:0]   pattern_q, pattern_d;
    logic                tick_q, tick_d;
    logic [REF_W-1:0]    w_sel;
    logic [31:0]         w_limit;
    logic                w_wrap;
`ifdef LED_PING_PONG_EN
    logic                bdir_q, bdir_d;
`endif

    function automatic logic [N_LEDS-1:0] rotate(input logic [N_LEDS-1:0] p,
                                                 input logic right);
        logic [N_LEDS-1:0] r;
        for (int i = 0; i < N_LEDS; i++) begin
            r[i] = right ? p[(i + 1) % N_LEDS] : p[(i + N_LEDS - 1) % N_LEDS];
        end
        return r;
    endfunction

    always_comb begin
        state_d   = state_q;
        ref_d     = ref_q;
        cnt_d     = cnt_q;
        pattern_d = pattern_q;
        tick_d    = 1'b0;
`ifdef LED_PING_PONG_EN
        bdir_d    = bdir_q;
`endif
        case (mode_q)
            2'b00:   w_target = S_SHIFT;
            2'b01:   w_target = S_FLASH;
`ifdef LED_PING_PONG_EN
            2'b10:   w_target = S_PING;
`endif
            default: w_target = S_HOLD;
        endcase

        w_sel   = (32'(bus.i_ref_sel) >= N_REF) ? REF_W'(N_REF - 1) : bus.i_ref_sel;
        w_limit = 32'(BASE_LIMIT) << w_sel;
        w_wrap  = (32'(cnt_q) == (w_limit - 32'd1));

        // Disabled means fully frozen, including pending mode/rate changes.
        if (bus.i_enable) begin
            ref_d = bus.i_ref_sel;
            if (w_target != state_q) begin
                state_d = w_target;
                cnt_d   = '0;
                case (w_target)
                    S_SHIFT: pattern_d = c_pat_one;
                    S_FLASH: pattern_d = '0;
`ifdef LED_PING_PONG_EN
                    S_PING: begin
                        pattern_d = c_pat_one;
                        bdir_d    = 1'b0;
                    end
`endif
                    default: ;
                endcase
`ifdef LED_PING_PONG_EN
                if (w_target == S_SHIFT) bdir_d = 1'b0;
`endif
            end else if (bus.i_ref_sel != ref_q) begin
                cnt_d = '0;
            end else if (w_wrap) begin
                cnt_d  = '0;
                tick_d = 1'b1;
                case (state_q)
                    S_SHIFT: pattern_d = rotate(pattern_q, bus.i_dir);
                    S_FLASH: pattern_d = ~pattern_q;
`ifdef LED_PING_PONG_EN
                    S_PING: begin
                        // End LEDs turn the bounce around on the same step.
                        if (N_LEDS > 1) begin
                            if (!bdir_q) begin
                                if (pattern_q[N_LEDS-1]) begin
                                    bdir_d    = 1'b1;
                                    pattern_d = pattern_q >> 1;
                                end else begin
                                    pattern_d = pattern_q << 1;
                                end
                            end else if (pattern_q[0]) begin
                                bdir_d    = 1'b0;
                                pattern_d = pattern_q << 1;
                            end else begin
                                pattern_d = pattern_q >> 1;
                            end
                        end
                    end
`endif
                    default: ;
                endcase
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (i_ck_reset) begin
            state_q   <= S_SHIFT;
            mode_q    <= 2'b00;
            ref_q     <= bus.i_ref_sel;
            cnt_q     <= '0;
            pattern_q <= c_pat_one;
            tick_q    <= 1'b0;
`ifdef LED_PING_PONG_EN
            bdir_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            mode_q    <= bus.i_mode;
            ref_q     <= ref_d;
            cnt_q     <= cnt_d;
            pattern_q <= pattern_d;
            tick_q    <= tick_d;
`ifdef LED_PING_PONG_EN
            bdir_q    <= bdir_d;
`endif
        end
    end

    assign bus.o_led  = pattern_q;
    assign bus.o_tick = tick_q;

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        assign bus.o_led_ch[c*N_LEDS +: N_LEDS] = pattern_q & {N_LEDS{bus.i_color[c]}};
    end

endmodule

`default_nettype wire

// File: tb/tb_led_pattern_engine.sv
// ============================================================================
// Module      : tb_led_pattern_engine
// Description : Directed self-checking bench for led_pattern_engine (4 LEDs,
//               3 channels, 4 rates, base limit 4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_led_pattern_engine;
    logic clock;
    logic i_ck_reset;
    int   checks   = 0;
    int   failures = 0;

    led_pattern_if #(.N_LEDS(4), .N_CH(3), .N_REF(4)) bus ();

    led_pattern_engine #(
        .N_LEDS(4), .N_CH(3), .N_REF(4), .BASE_LIMIT(4)
    ) dut (
        .clock      (clock),
        .i_ck_reset (i_ck_reset),
        .bus        (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    logic [3:0] ping_exp [7];
    logic [3:0] last_led;

    initial begin
`ifdef LED_PING_PONG_EN
        ping_exp = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
`else
        ping_exp = '{4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111};
`endif
        i_ck_reset    = 1'b1;
        bus.i_enable  = 1'b1;
        bus.i_ref_sel = 2'd0;
        bus.i_dir     = 1'b0;
        bus.i_mode    = 2'b00;
        bus.i_color   = 3'b000;

        // Reset held for three enabled cycles
        wait_cyc(3);
        chk("rst_led", 32'(bus.o_led), 32'h1);
        chk("rst_led_ch", 32'(bus.o_led_ch), 32'h0);
        chk("rst_tick", 32'(bus.o_tick), 32'h0);

        // SHIFT left at rate 0
        i_ck_reset  = 1'b0;
        bus.i_color = 3'b111;
        wait_cyc(3);
        chk("shl_pre_led", 32'(bus.o_led), 32'h1);
        chk("shl_pre_tick", 32'(bus.o_tick), 32'h0);
        wait_cyc(1);
        chk("shl_s1_led", 32'(bus.o_led), 32'h2);
        chk("shl_s1_tick", 32'(bus.o_tick), 32'h1);
        chk("shl_s1_ch", 32'(bus.o_led_ch), 32'h222);
        wait_cyc(1);
        chk("shl_tick_pulse", 32'(bus.o_tick), 32'h0);
        wait_cyc(3);
        chk("shl_s2_led", 32'(bus.o_led), 32'h4);
        chk("shl_s2_tick", 32'(bus.o_tick), 32'h1);
        wait_cyc(4);
        chk("shl_s3_led", 32'(bus.o_led), 32'h8);
        wait_cyc(2);
        bus.i_dir = 1'b1;
        wait_cyc(2);
        chk("dir_flip_led", 32'(bus.o_led), 32'h4);
        chk("dir_flip_tick", 32'(bus.o_tick), 32'h1);

        // SHIFT right at rate 1, then rate change mid-period
        i_ck_reset    = 1'b1;
        bus.i_ref_sel = 2'd1;
        wait_cyc(1);
        chk("rst2_led", 32'(bus.o_led), 32'h1);
        chk("rst2_tick", 32'(bus.o_tick), 32'h0);
        i_ck_reset = 1'b0;
        wait_cyc(7);
        chk("shr_pre_led", 32'(bus.o_led), 32'h1);
        wait_cyc(1);
        chk("shr_s1_led", 32'(bus.o_led), 32'h8);
        chk("shr_s1_tick", 32'(bus.o_tick), 32'h1);
        wait_cyc(8);
        chk("shr_s2_led", 32'(bus.o_led), 32'h4);
        wait_cyc(3);
        bus.i_ref_sel = 2'd3;
        wait_cyc(32);
        chk("ref3_pre_led", 32'(bus.o_led), 32'h4);
        chk("ref3_pre_tick", 32'(bus.o_tick), 32'h0);
        wait_cyc(1);
        chk("ref3_s_led", 32'(bus.o_led), 32'h2);
        chk("ref3_s_tick", 32'(bus.o_tick), 32'h1);

        // FLASH with channel masking
        bus.i_mode    = 2'b01;
        bus.i_ref_sel = 2'd0;
        bus.i_color   = 3'b001;
        bus.i_dir     = 1'b0;
        wait_cyc(1);
        chk("fl_reg_led", 32'(bus.o_led), 32'h2);
        wait_cyc(1);
        chk("fl_reload_led", 32'(bus.o_led), 32'h0);
        chk("fl_reload_tick", 32'(bus.o_tick), 32'h0);
        wait_cyc(4);
        chk("fl_s1_led", 32'(bus.o_led), 32'hF);
        chk("fl_s1_tick", 32'(bus.o_tick), 32'h1);
        chk("fl_s1_ch", 32'(bus.o_led_ch), 32'h00F);
        wait_cyc(4);
        chk("fl_s2_led", 32'(bus.o_led), 32'h0);
        bus.i_color = 3'b110;
        wait_cyc(4);
        chk("fl_s3_led", 32'(bus.o_led), 32'hF);
        chk("fl_s3_ch", 32'(bus.o_led_ch), 32'hFF0);

        // PING (or HOLD when ping-pong is compiled out)
        bus.i_mode = 2'b10;
        wait_cyc(2);
`ifdef LED_PING_PONG_EN
        chk("pp_reload_led", 32'(bus.o_led), 32'h1);
`else
        chk("pp_reload_led", 32'(bus.o_led), 32'hF);
`endif
        chk("pp_reload_tick", 32'(bus.o_tick), 32'h0);
        for (int k = 0; k < 7; k++) begin
            wait_cyc(3);
            chk($sformatf("pp_pre%0d_tick", k), 32'(bus.o_tick), 32'h0);
            wait_cyc(1);
            chk($sformatf("pp_s%0d_led", k), 32'(bus.o_led), 32'(ping_exp[k]));
            chk($sformatf("pp_s%0d_tick", k), 32'(bus.o_tick), 32'h1);
        end
        last_led = ping_exp[6];

        // Enable low for 20 cycles two counts into a period
        wait_cyc(2);
        bus.i_enable = 1'b0;
        wait_cyc(20);
        chk("dis_led", 32'(bus.o_led), 32'(last_led));
        chk("dis_tick", 32'(bus.o_tick), 32'h0);
        bus.i_enable = 1'b1;
        wait_cyc(1);
        chk("reen_pre_led", 32'(bus.o_led), 32'(last_led));
        chk("reen_pre_tick", 32'(bus.o_tick), 32'h0);
        wait_cyc(1);
`ifdef LED_PING_PONG_EN
        chk("reen_s_led", 32'(bus.o_led), 32'h4);
`else
        chk("reen_s_led", 32'(bus.o_led), 32'hF);
`endif
        chk("reen_s_tick", 32'(bus.o_tick), 32'h1);

        // Reset two cycles into a period
        wait_cyc(2);
        i_ck_reset = 1'b1;
        bus.i_mode = 2'b00;
        wait_cyc(1);
        chk("rst3_led", 32'(bus.o_led), 32'h1);
        chk("rst3_tick", 32'(bus.o_tick), 32'h0);
        i_ck_reset = 1'b0;
        wait_cyc(3);
        chk("rst3_pre_led", 32'(bus.o_led), 32'h1);
        wait_cyc(1);
        chk("rst3_s_led", 32'(bus.o_led), 32'h2);
        chk("rst3_s_tick", 32'(bus.o_tick), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/led_pattern_engine.md
# led_pattern_engine

Parametrised LED pattern generator for the board top level. It drives an N-LED bank with one-hot shift, all-on/all-off flash, ping-pong bounce or hold patterns, stepping at a rate chosen at run time from N_REF prescaler limits. The same pattern is fanned out to N_CH colour channels under a channel mask. It replaces fixed 4-LED, 2-rate, 2-mode sequencers. Inputs come from the switch/button decode in the top; outputs drive the LED pins directly.

## Interface

- N_LEDS, 4: number of LEDs in the bank (≥1)
- N_CH, 3: colour channels per LED (channel 0 = R, 1 = G, 2 = B)
- N_REF, 4: number of selectable step rates (≥2)
- BASE_LIMIT, 4: clocks per step at i_ref_sel=0; rate k uses BASE_LIMIT<<k (≥2)
- REF_W, clog2(N_REF): width of i_ref_sel

- clock  in  1  system clock, all logic on rising edge
- i_ck_reset  in  1  synchronous reset, active-high
- i_enable  in  1  count enable; low freezes prescaler and pattern
- i_ref_sel  in  REF_W  step-rate select; values ≥N_REF treated as N_REF-1
- i_dir  in  1  0 = toward MSB (left), 1 = toward LSB (right)
- i_mode  in  2  00 shift, 01 flash, 10 ping-pong, 11 hold
- i_color  in  N_CH  channel enable mask
- o_led  out  N_LEDS  mono pattern
- o_led_ch  out  N_LEDS*N_CH  bit c*N_LEDS+i = o_led[i] & i_color[c]
- o_tick  out  1  one-cycle pulse on each pattern step

## Operation

- Prescaler cnt, width clog2(BASE_LIMIT<<(N_REF-1)). With i_enable=1: cnt==limit-1 → cnt=0, step; else cnt+1. limit = BASE_LIMIT<<sel.
- Mode FSM states SHIFT, FLASH, PING, HOLD, following registered i_mode. Internal bounce bit bdir (0 = toward MSB).
- Step actions:
  - SHIFT: rotate by one toward the direction given by i_dir (MSB wraps to LSB and vice versa).
  - FLASH: pattern = ~pattern, giving an all-zero / all-one toggle.
  - PING: move the single 1 one position per bdir. If the 1 is at bit N_LEDS-1 and bdir=0, set bdir=1 and move to N_LEDS-2. Mirror this at bit 0. End LEDs are lit for one step only. i_dir ignored.
  - HOLD: pattern unchanged; o_tick still pulses.
- Mode change (registered i_mode differs from previous): reload on the next edge, taking precedence over any step.
  - SHIFT/PING: pattern = 1 (LSB), bdir=0.
  - FLASH: pattern = 0.
  - HOLD: keep pattern.
  - In all cases cnt=0.
- i_ref_sel change: cnt=0 on next edge; pattern unaffected.
- i_dir change in SHIFT takes effect on the next step; no reload.
- N_LEDS=1: SHIFT/PING hold the single LED on; FLASH toggles it.
- o_led_ch is combinational from the registered pattern and i_color.

## Timing

- Reset (i_ck_reset=1 at an edge) wins over everything:
  - Pattern = 1, so o_led = 0…01. cnt=0, bdir=0, o_tick=0, mode state = SHIFT.
  - o_led_ch follows o_led masked by i_color.
- After release with enable high, first step at the edge ending the limit-th enabled cycle. The new pattern and o_tick=1 are visible together for exactly one cycle.
- Step period = limit cycles exactly; no extra cycle at wrap, at bounce turnaround or in HOLD.
- i_enable low: cnt, pattern and bdir held, o_tick=0. On re-enable, counting resumes from the held cnt.
- Reload after a mode change is visible one cycle after the input change is registered (two edges after i_mode changes).

## Configuration

- LED_PING_PONG_EN:
  - Defined: mode 10 behaves as PING above.
  - Undefined: the PING state and bdir are removed, and mode 10 is decoded as HOLD, including the mode-change reload rule for HOLD.

## Test plan

- Reset with i_color=000: o_led=0001, o_led_ch=0, o_tick=0. Hold reset 3 cycles with i_enable=1: pattern and cnt stay at reset values.
- SHIFT, dir=0, ref=0, enable=1: o_led 0001→0010→0100→1000→0001, one step every 4 clocks, o_tick coincident with each change. Switch to dir=1 mid-period: next step goes 1000→0100 with no reload.
- SHIFT, dir=1, ref=1: o_led 0001→1000→0100 every 8 clocks. Change ref to 3 mid-period: cnt clears, next step after exactly 32 clocks.
- FLASH, color=001: o_led 0000→1111→0000 every 4 clocks. o_led_ch[3:0]=o_led, o_led_ch[11:4]=0. Change color to 110: only bits 11:4 follow.
- PING, ref=0 with LED_PING_PONG_EN: 0001,0010,0100,1000,0100,0010,0001,0010 at 4-clock steps. Without the macro: o_led stays at the prior pattern.
- i_enable low for 20 cycles mid-period: o_led frozen, o_tick=0; remaining count resumes after re-enable. Reset asserted 2 cycles into a period: o_led=0001 and cnt=0 on next edge, first step 4 clocks after release.
